// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// access-size codes, FSM states and decode helpers.
package lsu_pkg;

    localparam int WADDR_W_DEFAULT = 14;

    // RISC-V load/store funct3 encodings (stores reuse the B/H/W codes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size codes carried in funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } lsu_state_e;

    // Byte-lane mask of an access that starts at lane 0
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Encodings that are neither a legal load nor a legal store
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic ill;
        if (f3[1:0] == 2'b11) begin
            ill = 1'b1;
        end else if (we) begin
            ill = f3[2];
        end else begin
            ill = (f3 == 3'b110);
        end
        return ill;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake plus the four byte-lane RAM port of the LSU.
// master = requester side (core and memory model), slave = the LSU.
interface dmem_lsu_if #(
    parameter int WADDR_W = lsu_pkg::WADDR_W_DEFAULT
) ();
    logic               req_valid_i;
    logic               req_ready_o;
    logic               req_we_i;
    logic [2:0]         req_funct3_i;
    logic [31:0]        req_addr_i;
    logic [31:0]        req_wdata_i;
    logic [WADDR_W-1:0] mem_addr_o;
    logic [3:0]         mem_wren_o;
    logic [31:0]        mem_wdata_o;
    logic [31:0]        mem_rdata_i;
    logic               rsp_valid_o;
    logic [31:0]        rsp_rdata_o;
    logic               rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, mem_addr_o, mem_wren_o, mem_wdata_o,
               rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, mem_addr_o, mem_wren_o, mem_wdata_o,
               rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed bytes out of a two-word window
// ({beat2 word, beat1 word}) and applies sign or zero extension.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] sel_s;

    assign sel_s = 32'(window >> {offset, 3'b000});

    // Extend the selected byte/halfword according to the load type
    always_comb begin
        rdata = 32'h0000_0000;
        case (funct3)
            F3_B:    rdata = {{24{sel_s[7]}}, sel_s[7:0]};
            F3_H:    rdata = {{16{sel_s[15]}}, sel_s[15:0]};
            F3_W:    rdata = sel_s;
            F3_BU:   rdata = {24'h00_0000, sel_s[7:0]};
            F3_HU:   rdata = {16'h0000, sel_s[15:0]};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit in front of four byte-lane RAMs. Misaligned
// accesses that spill past a word boundary take a second beat on word+1.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int WADDR_W = WADDR_W_DEFAULT
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    dmem_lsu_if.slave bus
);

    lsu_state_e         state_r;
    lsu_state_e         state_n;

    // Request decode
    logic [1:0]         req_off_s;
    logic [WADDR_W-1:0] req_word_s;
    logic               illegal_s;
    logic [7:0]         req_mask_s;
    logic [63:0]        req_wwin_s;
    logic               cross_s;
    logic               unused_s;

    // Second-beat context captured on a crossing accept
    logic               capture_s;
    logic [WADDR_W-1:0] word_r;
    logic [1:0]         off_r;
    logic [2:0]         funct3_r;
    logic               we_r;
    logic [31:0]        wdata2_r;
    logic [3:0]         wren2_r;
    logic [31:0]        hold_r;

    // Memory port
    logic [WADDR_W-1:0] last_addr_r;
    logic [WADDR_W-1:0] mem_addr_s;
    logic [3:0]         mem_wren_s;
    logic [31:0]        mem_wdata_s;

    // Load alignment
    logic [63:0]        align_win_s;
    logic [1:0]         align_off_s;
    logic [2:0]         align_f3_s;
    logic [31:0]        align_data_s;

    // Response
    logic               rsp_valid_r;
    logic               rsp_err_r;
    logic [31:0]        rsp_rdata_r;
    logic               rsp_valid_n;
    logic               rsp_err_n;
    logic [31:0]        rsp_rdata_n;

    assign req_off_s  = bus.req_addr_i[1:0];
    assign req_word_s = bus.req_addr_i[WADDR_W+1:2];
    assign unused_s   = ^bus.req_addr_i[31:WADDR_W+2];
    assign illegal_s  = funct3_illegal(bus.req_we_i, bus.req_funct3_i);

    // Lane mask and store data over two words; the upper half is the second beat
    assign req_mask_s = {4'b0000, size_mask(bus.req_funct3_i[1:0])} << req_off_s;
    assign req_wwin_s = {32'h0000_0000, bus.req_wdata_i} << {req_off_s, 3'b000};
    assign cross_s    = (req_mask_s[7:4] != 4'b0000) && !illegal_s;

    assign bus.req_ready_o = (state_r == ST_IDLE);
    assign bus.mem_addr_o  = mem_addr_s;
    assign bus.mem_wren_o  = mem_wren_s;
    assign bus.mem_wdata_o = mem_wdata_s;
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_rdata_o = rsp_rdata_r;
    assign bus.rsp_err_o   = rsp_err_r;

    // Alignment window: live read word alone in IDLE, {live, held} in BEAT2
    always_comb begin
        align_win_s = {32'h0000_0000, bus.mem_rdata_i};
        align_off_s = req_off_s;
        align_f3_s  = bus.req_funct3_i;
        if (state_r == ST_BEAT2) begin
            align_win_s = {bus.mem_rdata_i, hold_r};
            align_off_s = off_r;
            align_f3_s  = funct3_r;
        end else begin
            align_win_s = {32'h0000_0000, bus.mem_rdata_i};
        end
    end

    lsu_load_align u_align (
        .window (align_win_s),
        .offset (align_off_s),
        .funct3 (align_f3_s),
        .rdata  (align_data_s)
    );

    // FSM next state, memory beat drive and next response values
    always_comb begin
        state_n     = state_r;
        mem_addr_s  = last_addr_r;
        mem_wren_s  = 4'b0000;
        mem_wdata_s = 32'h0000_0000;
        capture_s   = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    mem_addr_s = req_word_s;
                    if (illegal_s) begin
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else begin
                        if (bus.req_we_i) begin
                            mem_wren_s  = req_mask_s[3:0];
                            mem_wdata_s = req_wwin_s[31:0];
                        end else begin
                            mem_wren_s  = 4'b0000;
                        end
                        if (cross_s) begin
                            state_n   = ST_BEAT2;
                            capture_s = 1'b1;
                        end else begin
                            rsp_valid_n = 1'b1;
                            rsp_rdata_n = bus.req_we_i ? 32'h0000_0000 : align_data_s;
                        end
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BEAT2: begin
                mem_addr_s  = word_r + WADDR_W'(1);
                if (we_r) begin
                    mem_wren_s  = wren2_r;
                    mem_wdata_s = wdata2_r;
                end else begin
                    mem_wren_s  = 4'b0000;
                end
                rsp_valid_n = 1'b1;
                rsp_rdata_n = we_r ? 32'h0000_0000 : align_data_s;
                state_n     = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Capture beat-1 read data and the second-beat store context
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_r   <= '0;
            off_r    <= 2'b00;
            funct3_r <= 3'b000;
            we_r     <= 1'b0;
            wdata2_r <= 32'h0000_0000;
            wren2_r  <= 4'b0000;
            hold_r   <= 32'h0000_0000;
        end else if (capture_s) begin
            word_r   <= req_word_s;
            off_r    <= req_off_s;
            funct3_r <= bus.req_funct3_i;
            we_r     <= bus.req_we_i;
            wdata2_r <= bus.req_we_i ? req_wwin_s[63:32] : 32'h0000_0000;
            wren2_r  <= bus.req_we_i ? req_mask_s[7:4] : 4'b0000;
            hold_r   <= bus.mem_rdata_i;
        end
    end

    // Memory address holds its last driven value between beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_addr_r <= '0;
        end else begin
            last_addr_r <= mem_addr_s;
        end
    end

    // Registered completion pulse and its data/error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= rsp_valid_n;
            rsp_err_r   <= rsp_err_n;
            rsp_rdata_r <= rsp_rdata_n;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a driver issues requests and queues expected
// responses and store beats; a monitor pops and compares as the DUT presents them.
module tb_dmem_lsu;

    localparam int AW = 14;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    wren;
    } beat_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    rsp_t  rsp_q[$];
    beat_t beat_q[$];
    logic [31:0] mem [0:(1<<AW)-1];

    dmem_lsu_if #(.WADDR_W(AW)) bus ();

    dmem_lsu #(.WADDR_W(AW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Four byte-lane RAMs with asynchronous read
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.mem_wren_o[k]) mem[bus.mem_addr_o][8*k +: 8] <= bus.mem_wdata_o[8*k +: 8];
        end
    end
    assign bus.mem_rdata_i = mem[bus.mem_addr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [3:0] w);
        beat_t b;
        b.addr = a;
        b.wren = w;
        beat_q.push_back(b);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_rsp,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        int   waits;
        rsp_t e;
        waits = 0;
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        while (!bus.req_ready_o && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.req_ready_o) begin
            n_checks++;
            $display("FAIL accept_timeout: ready %b expected 1 for addr %h", bus.req_ready_o, addr);
        end else begin
            if (exp_rsp) begin
                e.rdata = exp_rdata;
                e.err   = exp_err;
                e.cyc   = cyc + lat;
                rsp_q.push_back(e);
            end
            @(negedge clk);
        end
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_addr_i   = 32'h0000_0000;
        bus.req_wdata_i  = 32'h0000_0000;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp, input int lat);
        issue(1'b0, f3, a, 32'h0000_0000, 1'b1, exp, 1'b0, lat);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input int lat);
        issue(1'b1, f3, a, d, 1'b1, 32'h0000_0000, 1'b0, lat);
    endtask

    // Monitor: responses and store beats checked against the queues
    initial begin
        rsp_t  e;
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (bus.rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b expected none", bus.rsp_rdata_o, bus.rsp_err_o);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                    chk("rsp_err", {31'b0, bus.rsp_err_o}, {31'b0, e.err});
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.mem_wren_o != 4'b0000) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr %h wren %b expected none", bus.mem_addr_o, bus.mem_wren_o);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_addr", 32'(bus.mem_addr_o), 32'(b.addr));
                    chk("beat_wren", {28'b0, bus.mem_wren_o}, {28'b0, b.wren});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_addr_i   = 32'h0000_0000;
        bus.req_wdata_i  = 32'h0000_0000;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
        chk("reset_wren", {28'b0, bus.mem_wren_o}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, bus.req_ready_o}, 32'h1);
        chk("reset_rsp_rdata", bus.rsp_rdata_o, 32'h0);
        chk("reset_rsp_err", {31'b0, bus.rsp_err_o}, 32'h0);

        // Aligned word store and reads
        beat(14'h0004, 4'b1111); st(3'b010, 32'h0010, 32'hDEADBEEF, 1);
        ld(3'b010, 32'h0010, 32'hDEADBEEF, 1);
        ld(3'b000, 32'h0013, 32'hFFFFFFDE, 1);
        ld(3'b100, 32'h0013, 32'h000000DE, 1);
        ld(3'b001, 32'h0012, 32'hFFFFDEAD, 1);

        // Crossing word store and loads
        beat(14'h0005, 4'b1111); st(3'b010, 32'h0014, 32'h55667788, 1);
        beat(14'h0004, 4'b1000); beat(14'h0005, 4'b0111); st(3'b010, 32'h0013, 32'h11223344, 2);
        ld(3'b010, 32'h0013, 32'h11223344, 2);
        ld(3'b010, 32'h0014, 32'h55112233, 1);
        ld(3'b101, 32'h0015, 32'h00001122, 1);

        // Halfword across the top of the address space
        beat(14'h3FFF, 4'b1000); beat(14'h0000, 4'b0001); st(3'b001, 32'hFFFF, 32'h0000A5C3, 2);
        ld(3'b001, 32'hFFFF, 32'hFFFFA5C3, 2);
        ld(3'b101, 32'hFFFF, 32'h0000A5C3, 2);

        // Illegal encodings: error response, nothing written
        issue(1'b0, 3'b111, 32'h0010, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 3'b110, 32'h0013, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b1, 3'b100, 32'h0010, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b1, 3'b011, 32'h0013, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 1);
        ld(3'b010, 32'h0010, 32'h44ADBEEF, 1);

        // Byte store into a middle lane
        beat(14'h0004, 4'b0100); st(3'b000, 32'h0012, 32'h123456EE, 1);
        ld(3'b000, 32'h0012, 32'hFFFFFFEE, 1);

        // Reset in the second beat of a crossing store
        beat(14'h0004, 4'b1000);
        issue(1'b1, 3'b010, 32'h0013, 32'hCAFEBABE, 1'b0, 32'h0, 1'b0, 2);
        rst_n = 1'b0;
        #2;
        chk("abort_wren", {28'b0, bus.mem_wren_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'b0, bus.req_ready_o}, 32'h1);
        ld(3'b010, 32'h0014, 32'h55112233, 1);
        ld(3'b100, 32'h0013, 32'h000000BE, 1);

        repeat (5) @(negedge clk);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
        chk("beat_queue_empty", 32'(beat_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
